// File: rtl/fourx_linear_interpolator_tc.sv
// 1:4 linear-interpolating upsampler: each accepted sample closes a segment that is
// replayed over four clocks as a + floor(k*(b-a)/4), k = 0..3.
module fourx_linear_interpolator_tc #(
   parameter int WIDTH      = 13,
   parameter int HOLD_LIMIT = 255
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic signed [WIDTH-1:0] in,
   input  logic                    in_valid,
   output logic signed [WIDTH-1:0] out,
   output logic                    out_valid,
   output logic                    underrun,
   output logic                    overrun
);

   typedef enum logic [1:0] {EMPTY, PRIMED, RUN, HOLD} state_t;

   localparam logic [7:0] HOLD_LAST = 8'(HOLD_LIMIT - 1);

   state_t                  state, state_n;
   logic signed [WIDTH-1:0] a, a_n, b, b_n, out_n;
   logic signed [WIDTH:0]   d, d_n, diff_in;
   logic [1:0]              ph, ph_n;
   logic [7:0]              hold_cnt, hold_n;
   logic                    valid_n, under_n, over_n, load;
   logic signed [WIDTH+2:0] ph_ext, d_ext, prod, ramp;
   logic                    unused_ramp_msbs;

   // Ramp point: the product is at most 3*(2^WIDTH - 1), so WIDTH+3 bits never overflow.
   always_comb begin
      ph_ext  = {{(WIDTH+1){1'b0}}, ph};
      d_ext   = {{2{d[WIDTH]}}, d};
      prod    = ph_ext * d_ext;
      ramp    = {{3{a[WIDTH-1]}}, a} + (prod >>> 2);
      diff_in = {in[WIDTH-1], in} - {b[WIDTH-1], b};
   end

   // The ramp always lies between a and b, so its upper bits are pure sign extension.
   assign unused_ramp_msbs = ^ramp[WIDTH+2:WIDTH];

   always_comb begin
      state_n = state;
      a_n     = a;
      b_n     = b;
      d_n     = d;
      ph_n    = ph;
      hold_n  = hold_cnt;
      out_n   = '0;
      valid_n = 1'b0;
      under_n = 1'b0;
      over_n  = 1'b0;
      load    = 1'b0;
      case (state)
         EMPTY: begin
            if (in_valid) begin
               b_n     = in;
               state_n = PRIMED;
            end
         end
         PRIMED: load = in_valid;
         RUN: begin
            out_n   = ramp[WIDTH-1:0];
            valid_n = 1'b1;
            if (ph == 2'd3) begin
               if (in_valid) begin
                  load = 1'b1;
               end else begin
                  state_n = HOLD;
                  hold_n  = '0;
               end
            end else begin
               ph_n   = ph + 2'd1;
               over_n = in_valid;
            end
         end
         HOLD: begin
            out_n   = b;
            valid_n = 1'b1;
            under_n = (hold_cnt == 8'd0);
            if (in_valid) begin
               load = 1'b1;
            end else if (hold_cnt == HOLD_LAST) begin
               state_n = PRIMED;
               hold_n  = '0;
            end else begin
               hold_n = hold_cnt + 8'd1;
            end
         end
         default: state_n = EMPTY;
      endcase
      // A new segment always runs from the last accepted sample to the incoming one.
      if (load) begin
         a_n     = b;
         b_n     = in;
         d_n     = diff_in;
         ph_n    = '0;
         hold_n  = '0;
         state_n = RUN;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= EMPTY;
         a         <= '0;
         b         <= '0;
         d         <= '0;
         ph        <= '0;
         hold_cnt  <= '0;
         out       <= '0;
         out_valid <= 1'b0;
         underrun  <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         state     <= state_n;
         a         <= a_n;
         b         <= b_n;
         d         <= d_n;
         ph        <= ph_n;
         hold_cnt  <= hold_n;
         out       <= out_n;
         out_valid <= valid_n;
         underrun  <= under_n;
         overrun   <= over_n;
      end
   end

endmodule
